// File: rtl/param_stack.sv
// param_stack: parametrised LIFO stack with occupancy count, registered pop
// data/valid, same-cycle replace-top and sticky overflow/underflow flags.
// Optional high-water-mark output enabled by defining PARAM_STACK_HWM_EN.
module param_stack #(
    parameter int N = 16,
    parameter int DEPTH = 16,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic [N-1:0]  push_data,
    input  logic          err_clr,
    output logic [N-1:0]  pop_data,
    output logic          pop_valid,
    output logic [N-1:0]  top,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full,
    output logic          overflow,
    output logic          underflow
`ifdef PARAM_STACK_HWM_EN
    ,
    output logic [CW-1:0] hwm
`endif
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] ONE_C = CW'(1);

    logic [N-1:0]  mem_q [DEPTH];
    logic [CW-1:0] count_q, count_d;
    logic [N-1:0]  pop_data_q, pop_data_d;
    logic          pop_valid_q, pop_valid_d;
    logic          empty_q, empty_d;
    logic          full_q, full_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [AW-1:0] top_idx;
    logic [AW-1:0] push_idx;
    logic [N-1:0]  top_word;

    // Top entry sits at count-1; the free slot for a push sits at count.
    assign top_idx  = AW'(count_q - ONE_C);
    assign push_idx = AW'(count_q);
    assign top_word = mem_q[top_idx];

    // Next-state decode for every push/pop combination, evaluated on the
    // pre-edge state; the error set condition overrides a concurrent clear.
    always_comb begin
        count_d     = count_q;
        pop_data_d  = pop_data_q;
        pop_valid_d = 1'b0;
        overflow_d  = err_clr ? 1'b0 : overflow_q;
        underflow_d = err_clr ? 1'b0 : underflow_q;
        mem_we      = 1'b0;
        mem_waddr   = push_idx;
        unique case ({push, pop})
            2'b10: begin
                if (!full_q) begin
                    mem_we  = 1'b1;
                    count_d = count_q + ONE_C;
                end else begin
                    overflow_d = 1'b1;
                end
            end
            2'b01: begin
                if (!empty_q) begin
                    pop_data_d  = top_word;
                    pop_valid_d = 1'b1;
                    count_d     = count_q - ONE_C;
                end else begin
                    underflow_d = 1'b1;
                end
            end
            2'b11: begin
                if (!empty_q) begin
                    pop_data_d  = top_word;
                    pop_valid_d = 1'b1;
                    mem_we      = 1'b1;
                    mem_waddr   = top_idx;
                end else begin
                    mem_we      = 1'b1;
                    count_d     = ONE_C;
                    underflow_d = 1'b1;
                end
            end
            default: begin
            end
        endcase
        empty_d = (count_d == '0);
        full_d  = (count_d == DEPTH_C);
    end

    // Storage array is write-only on the clock and deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_waddr] <= push_data;
        end
    end

    // Control and status registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q     <= '0;
            pop_data_q  <= '0;
            pop_valid_q <= 1'b0;
            empty_q     <= 1'b1;
            full_q      <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            pop_data_q  <= pop_data_d;
            pop_valid_q <= pop_valid_d;
            empty_q     <= empty_d;
            full_q      <= full_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

`ifdef PARAM_STACK_HWM_EN
    logic [CW-1:0] hwm_q, hwm_d;

    // High-water mark tracks the largest count; a clear restarts it from now.
    always_comb begin
        hwm_d = hwm_q;
        if (err_clr) begin
            hwm_d = count_d;
        end else if (count_d > hwm_q) begin
            hwm_d = count_d;
        end
    end

    // High-water mark register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hwm_q <= '0;
        end else begin
            hwm_q <= hwm_d;
        end
    end

    assign hwm = hwm_q;
`endif

    assign pop_data  = pop_data_q;
    assign pop_valid = pop_valid_q;
    assign top       = empty_q ? '0 : top_word;
    assign count     = count_q;
    assign empty     = empty_q;
    assign full      = full_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;

endmodule

// File: tb/tb_param_stack.sv
// Testbench for param_stack: a DEPTH=4 instance exercises push/pop/replace/
// error behaviour; a DEPTH=5 instance covers non-power-of-two depth and the
// optional high-water mark (PARAM_STACK_HWM_EN).
module tb_param_stack;

    logic       clk = 1'b0;
    logic       reset;
    logic       push, pop, err_clr;
    logic [7:0] push_data;
    logic [7:0] pop_data, top;
    logic       pop_valid, empty, full, overflow, underflow;
    logic [2:0] count;

    logic       push5, pop5, err_clr5;
    logic [7:0] push_data5;
    logic [7:0] pop_data5, top5;
    logic       pop_valid5, empty5, full5, overflow5, underflow5;
    logic [2:0] count5;
`ifdef PARAM_STACK_HWM_EN
    logic [2:0] hwm5;
`endif

    int compared = 0;
    int mismatched = 0;

    logic [7:0] vals [4];

    // Free-running clock, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    param_stack #(.N(8), .DEPTH(4)) dut (
        .clk(clk), .reset(reset), .push(push), .pop(pop),
        .push_data(push_data), .err_clr(err_clr),
        .pop_data(pop_data), .pop_valid(pop_valid), .top(top),
        .count(count), .empty(empty), .full(full),
        .overflow(overflow), .underflow(underflow)
`ifdef PARAM_STACK_HWM_EN
        , .hwm()
`endif
    );

    param_stack #(.N(8), .DEPTH(5)) dut5 (
        .clk(clk), .reset(reset), .push(push5), .pop(pop5),
        .push_data(push_data5), .err_clr(err_clr5),
        .pop_data(pop_data5), .pop_valid(pop_valid5), .top(top5),
        .count(count5), .empty(empty5), .full(full5),
        .overflow(overflow5), .underflow(underflow5)
`ifdef PARAM_STACK_HWM_EN
        , .hwm(hwm5)
`endif
    );

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        push = 1'b1; push_data = 8'h77; tick;
        push = 1'b0; pop = 1'b1; tick;
        tick;
        pop = 1'b0; push = 1'b1; push_data = 8'h66; tick;
        push = 1'b0;
        @(negedge clk); #2;
        reset = 1'b0;
        #1;
        compared++; if (count !== 3'd0) begin mismatched++; $display("FAIL rst_count got %0d exp 0", count); end
        compared++; if (empty !== 1'b1) begin mismatched++; $display("FAIL rst_empty got %b exp 1", empty); end
        compared++; if (full !== 1'b0) begin mismatched++; $display("FAIL rst_full got %b exp 0", full); end
        compared++; if (top !== 8'h00) begin mismatched++; $display("FAIL rst_top got %h exp 00", top); end
        compared++; if (pop_data !== 8'h00) begin mismatched++; $display("FAIL rst_pop_data got %h exp 00", pop_data); end
        compared++; if (pop_valid !== 1'b0) begin mismatched++; $display("FAIL rst_pop_valid got %b exp 0", pop_valid); end
        compared++; if (overflow !== 1'b0) begin mismatched++; $display("FAIL rst_overflow got %b exp 0", overflow); end
        compared++; if (underflow !== 1'b0) begin mismatched++; $display("FAIL rst_underflow got %b exp 0", underflow); end
        #1 reset = 1'b1;
        tick;
        compared++; if (count !== 3'd0 || empty !== 1'b1) begin mismatched++; $display("FAIL post_rst_idle count %0d empty %b exp 0/1", count, empty); end
    endtask

    task automatic test_push_fill;
        vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44;
        for (int i = 0; i < 4; i++) begin
            push = 1'b1; push_data = vals[i]; tick;
            compared++; if (count !== 3'(i + 1)) begin mismatched++; $display("FAIL fill_count[%0d] got %0d exp %0d", i, count, i + 1); end
            compared++; if (top !== vals[i]) begin mismatched++; $display("FAIL fill_top[%0d] got %h exp %h", i, top, vals[i]); end
            compared++; if (full !== (i == 3)) begin mismatched++; $display("FAIL fill_full[%0d] got %b exp %b", i, full, (i == 3)); end
        end
        push_data = 8'h55; tick;
        push = 1'b0;
        compared++; if (overflow !== 1'b1) begin mismatched++; $display("FAIL ovf_flag got %b exp 1", overflow); end
        compared++; if (count !== 3'd4) begin mismatched++; $display("FAIL ovf_count got %0d exp 4", count); end
        compared++; if (top !== 8'h44) begin mismatched++; $display("FAIL ovf_top got %h exp 44", top); end
    endtask

    task automatic test_pop_drain;
        pop = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick;
            compared++; if (pop_data !== vals[3 - i]) begin mismatched++; $display("FAIL drain_data[%0d] got %h exp %h", i, pop_data, vals[3 - i]); end
            compared++; if (pop_valid !== 1'b1) begin mismatched++; $display("FAIL drain_valid[%0d] got %b exp 1", i, pop_valid); end
            compared++; if (count !== 3'(3 - i)) begin mismatched++; $display("FAIL drain_count[%0d] got %0d exp %0d", i, count, 3 - i); end
        end
        compared++; if (empty !== 1'b1 || full !== 1'b0) begin mismatched++; $display("FAIL drain_empty got e%b f%b exp e1 f0", empty, full); end
        tick;
        pop = 1'b0;
        compared++; if (underflow !== 1'b1) begin mismatched++; $display("FAIL unf_flag got %b exp 1", underflow); end
        compared++; if (pop_valid !== 1'b0) begin mismatched++; $display("FAIL unf_valid got %b exp 0", pop_valid); end
        compared++; if (pop_data !== 8'h11) begin mismatched++; $display("FAIL unf_data got %h exp 11", pop_data); end
        compared++; if (count !== 3'd0) begin mismatched++; $display("FAIL unf_count got %0d exp 0", count); end
        err_clr = 1'b1; tick; err_clr = 1'b0;
        compared++; if (overflow !== 1'b0 || underflow !== 1'b0) begin mismatched++; $display("FAIL clr_flags got o%b u%b exp o0 u0", overflow, underflow); end
    endtask

    task automatic test_replace;
        push = 1'b1; push_data = 8'h11; tick;
        push_data = 8'h22; tick;
        pop = 1'b1; push_data = 8'hAA; tick;
        pop = 1'b0;
        compared++; if (pop_data !== 8'h22) begin mismatched++; $display("FAIL rep_data got %h exp 22", pop_data); end
        compared++; if (pop_valid !== 1'b1) begin mismatched++; $display("FAIL rep_valid got %b exp 1", pop_valid); end
        compared++; if (top !== 8'hAA) begin mismatched++; $display("FAIL rep_top got %h exp AA", top); end
        compared++; if (count !== 3'd2) begin mismatched++; $display("FAIL rep_count got %0d exp 2", count); end
        push_data = 8'h33; tick;
        push_data = 8'h44; tick;
        compared++; if (full !== 1'b1) begin mismatched++; $display("FAIL rep_full got %b exp 1", full); end
        pop = 1'b1; push_data = 8'hBB; tick;
        push = 1'b0;
        compared++; if (pop_data !== 8'h44) begin mismatched++; $display("FAIL repfull_data got %h exp 44", pop_data); end
        compared++; if (count !== 3'd4 || top !== 8'hBB) begin mismatched++; $display("FAIL repfull_state count %0d top %h exp 4/BB", count, top); end
        compared++; if (overflow !== 1'b0 || underflow !== 1'b0) begin mismatched++; $display("FAIL repfull_flags got o%b u%b exp o0 u0", overflow, underflow); end
        vals[0] = 8'hBB; vals[1] = 8'h33; vals[2] = 8'hAA; vals[3] = 8'h11;
        for (int i = 0; i < 4; i++) begin
            tick;
            compared++; if (pop_data !== vals[i] || pop_valid !== 1'b1) begin mismatched++; $display("FAIL rep_order[%0d] got %h/%b exp %h/1", i, pop_data, pop_valid, vals[i]); end
        end
        pop = 1'b0; tick;
        compared++; if (pop_valid !== 1'b0 || pop_data !== 8'h11) begin mismatched++; $display("FAIL rep_hold got %h/%b exp 11/0", pop_data, pop_valid); end
    endtask

    task automatic test_empty_push_pop;
        push = 1'b1; pop = 1'b1; push_data = 8'h5A; tick;
        push = 1'b0; pop = 1'b0;
        compared++; if (count !== 3'd1 || top !== 8'h5A) begin mismatched++; $display("FAIL epp_state count %0d top %h exp 1/5A", count, top); end
        compared++; if (underflow !== 1'b1) begin mismatched++; $display("FAIL epp_unf got %b exp 1", underflow); end
        compared++; if (pop_valid !== 1'b0 || pop_data !== 8'h11) begin mismatched++; $display("FAIL epp_pop got %h/%b exp 11/0", pop_data, pop_valid); end
        err_clr = 1'b1; tick; err_clr = 1'b0;
        compared++; if (underflow !== 1'b0 || overflow !== 1'b0 || count !== 3'd1) begin mismatched++; $display("FAIL epp_clr got u%b o%b c%0d exp u0 o0 c1", underflow, overflow, count); end
        pop = 1'b1; tick;
        compared++; if (pop_data !== 8'h5A || pop_valid !== 1'b1) begin mismatched++; $display("FAIL epp_pop2 got %h/%b exp 5A/1", pop_data, pop_valid); end
        err_clr = 1'b1; tick;
        err_clr = 1'b0; pop = 1'b0;
        compared++; if (underflow !== 1'b1 || pop_valid !== 1'b0) begin mismatched++; $display("FAIL set_wins got u%b v%b exp u1 v0", underflow, pop_valid); end
        err_clr = 1'b1; tick; err_clr = 1'b0;
    endtask

    task automatic test_depth5_hwm;
        push5 = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            push_data5 = 8'(i); tick;
        end
        push5 = 1'b0; pop5 = 1'b1; tick;
        compared++; if (pop_data5 !== 8'h03 || pop_valid5 !== 1'b1) begin mismatched++; $display("FAIL d5_pop1 got %h/%b exp 03/1", pop_data5, pop_valid5); end
        tick;
        compared++; if (pop_data5 !== 8'h02) begin mismatched++; $display("FAIL d5_pop2 got %h exp 02", pop_data5); end
        pop5 = 1'b0; push5 = 1'b1; push_data5 = 8'h04; tick;
        compared++; if (count5 !== 3'd2 || top5 !== 8'h04 || full5 !== 1'b0) begin mismatched++; $display("FAIL d5_state got c%0d t%h f%b exp c2 t04 f0", count5, top5, full5); end
`ifdef PARAM_STACK_HWM_EN
        compared++; if (hwm5 !== 3'd3) begin mismatched++; $display("FAIL hwm_3 got %0d exp 3", hwm5); end
`endif
        for (int i = 5; i <= 7; i++) begin
            push_data5 = 8'(i); tick;
            compared++; if (full5 !== (i == 7)) begin mismatched++; $display("FAIL d5_full[%0d] got %b exp %b", i, full5, (i == 7)); end
        end
        push5 = 1'b0;
        compared++; if (count5 !== 3'd5 || top5 !== 8'h07 || empty5 !== 1'b0) begin mismatched++; $display("FAIL d5_full_state got c%0d t%h e%b exp c5 t07 e0", count5, top5, empty5); end
        compared++; if (overflow5 !== 1'b0 || underflow5 !== 1'b0) begin mismatched++; $display("FAIL d5_flags got o%b u%b exp o0 u0", overflow5, underflow5); end
`ifdef PARAM_STACK_HWM_EN
        compared++; if (hwm5 !== 3'd5) begin mismatched++; $display("FAIL hwm_5 got %0d exp 5", hwm5); end
`endif
        err_clr5 = 1'b1; tick;
`ifdef PARAM_STACK_HWM_EN
        compared++; if (hwm5 !== 3'd5) begin mismatched++; $display("FAIL hwm_clr got %0d exp 5", hwm5); end
`endif
        pop5 = 1'b1; tick;
        pop5 = 1'b0; err_clr5 = 1'b0;
        compared++; if (count5 !== 3'd4 || pop_data5 !== 8'h07) begin mismatched++; $display("FAIL d5_pop3 got c%0d d%h exp c4 d07", count5, pop_data5); end
`ifdef PARAM_STACK_HWM_EN
        compared++; if (hwm5 !== 3'd4) begin mismatched++; $display("FAIL hwm_clr_pop got %0d exp 4", hwm5); end
`endif
    endtask

    // Sequence every scenario, then print the summary.
    initial begin
        reset = 1'b0;
        push = 1'b0; pop = 1'b0; err_clr = 1'b0; push_data = 8'h00;
        push5 = 1'b0; pop5 = 1'b0; err_clr5 = 1'b0; push_data5 = 8'h00;
        tick; tick;
        reset = 1'b1;
        tick;
        test_reset;
        test_push_fill;
        test_pop_drain;
        test_replace;
        test_empty_push_pop;
        test_depth5_hwm;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
